// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial sequencer driving one external 1-bit full adder.
// Adds two WIDTH-bit operands LSB-first over WIDTH cycles, registering the
// carry between cycles, then presents result/cout with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_OVF_DET_EN (signed overflow flag on ovf).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             fa_in1,
  output logic             fa_in2,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 sum bits collected so far; the newest bit enters at the top.
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_bit;

  // A start is honoured only when no add is in flight.
  assign accept   = start && (state != RUN);
  assign last_bit = (state == RUN) && (cnt == LAST);
  assign sum_next = {fa_sum, sum_sh};

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; adder inputs come only from registers.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fa_in1    = 1'b0;
    fa_in2    = 1'b0;
    fa_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        fa_in1 = a_sh[0];
        fa_in2 = b_sh[0];
        fa_cin = carry_q;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand load, per-bit shifting and result capture on the final bit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sh    <= op_a;
      b_sh    <= op_b;
      carry_q <= cin_init;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= sum_next[WIDTH-1:1];
      carry_q <= fa_carry;
      cnt     <= cnt + 1'b1;
      if (last_bit) begin
        result <= sum_next;
        cout   <= fa_carry;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_DET_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= carry_q ^ fa_carry;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
